// File: rtl/gpc_arb_pkg.sv
// Shared widths, helper function and FIFO entry type for the time-multiplexed
// gpc31_3 arbiter.
package gpc_arb_pkg;

    localparam int GPC31_3_SRC0_W  = 1;
    localparam int GPC31_3_SRC1_W  = 3;
    localparam int GPC31_3_DST_W   = 3;
    // Widest requester ID the FIFO entry can carry; narrower IDs are zero-extended.
    localparam int GPC_ARB_MAX_IDW = 8;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic [GPC_ARB_MAX_IDW-1:0] id;
        logic [GPC31_3_DST_W-1:0]   dst;
    } gpc_arb_entry_t;

endpackage

// File: rtl/gpc31_3.sv
// Generalised parallel counter (3,1;3): dst = src0 + 2*popcount(src1).
module gpc31_3
    import gpc_arb_pkg::*;
(
    input  logic [GPC31_3_SRC0_W-1:0] src0,
    input  logic [GPC31_3_SRC1_W-1:0] src1,
    output logic [GPC31_3_DST_W-1:0]  dst
);

    logic [1:0] ones;

    assign ones = {1'b0, src1[0]} + {1'b0, src1[1]} + {1'b0, src1[2]};
    // Weight-2 column count sits above the single weight-1 bit.
    assign dst  = {ones, src0};

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or above ptr,
// ptr moves past the winner whenever advance is asserted.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            en,
    input  logic            advance,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_id,
    output logic            grant_valid
);

    logic [IDW-1:0] ptr;
    int             idx;

    always_comb begin
        // NOTE: every output gets a default before the search so no latch is inferred.
        grant       = '0;
        grant_id    = '0;
        grant_valid = 1'b0;
        idx         = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (en && !grant_valid && req[idx]) begin
                grant[idx]  = 1'b1;
                grant_id    = IDW'(idx);
                grant_valid = 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
        end
    end

endmodule

// File: rtl/gpc31_3_arbiter.sv
// One shared gpc31_3 counter, round-robin granted across NREQ requesters,
// results tagged with the requester ID and queued in a small output FIFO.
module gpc31_3_arbiter
    import gpc_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int IDW   = 2,
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ-1:0]   req_src0,
    input  logic [3*NREQ-1:0] req_src1,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [2:0]        rsp_dst
);

    localparam int CW = clog2_min1(DEPTH + 1);
    localparam int PW = clog2_min1(DEPTH);

    gpc_arb_entry_t            mem [DEPTH];
    gpc_arb_entry_t            wr_entry;
    gpc_arb_entry_t            head;
    logic [PW-1:0]             wr_ptr;
    logic [PW-1:0]             rd_ptr;
    logic [CW-1:0]             count;
    logic                      accept_en;
    logic                      push;
    logic                      pop;
    logic [IDW-1:0]            gid;
    logic [GPC31_3_SRC0_W-1:0] sel_src0;
    logic [GPC31_3_SRC1_W-1:0] sel_src1;
    logic [GPC31_3_DST_W-1:0]  sel_dst;

    // Registered count only: rsp_ready never reaches req_ready, so a full FIFO costs one bubble.
    assign accept_en = (count < CW'(DEPTH)) && !rst;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr (
        .clk         (clk),
        .rst         (rst),
        .req         (req_valid),
        .en          (accept_en),
        .advance     (push),
        .grant       (req_ready),
        .grant_id    (gid),
        .grant_valid (push)
    );

    assign sel_src0 = req_src0[gid];
    assign sel_src1 = req_src1[3*gid +: 3];

    gpc31_3 u_gpc (
        .src0 (sel_src0),
        .src1 (sel_src1),
        .dst  (sel_dst)
    );

    assign wr_entry.id  = GPC_ARB_MAX_IDW'(gid);
    assign wr_entry.dst = sel_dst;

    assign pop       = rsp_valid && rsp_ready;
    assign rsp_valid = (count != '0);
    assign head      = mem[rd_ptr];
    // Masked while empty so stale storage never shows on the response port.
    assign rsp_id    = rsp_valid ? IDW'(head.id) : '0;
    assign rsp_dst   = rsp_valid ? head.dst      : '0;

    // NOTE: FIFO storage is deliberately not reset; count/pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: tb/tb_gpc31_3_arbiter.sv
// Directed bench for gpc31_3_arbiter: reset, single grant, round-robin order,
// back-pressure, exhaustive operand sweep and mid-operation reset.
module tb_gpc31_3_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [3:0]  req_src0;
    logic [11:0] req_src1;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [2:0]  rsp_dst;

    int total = 0;
    int bad   = 0;

    gpc31_3_arbiter #(.NREQ(4), .IDW(2), .DEPTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_src0  (req_src0),
        .req_src1  (req_src1),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_dst   (rsp_dst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        req_src0  = '0;
        req_src1  = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        total++; if (rsp_id !== 2'd0) begin bad++; $display("FAIL reset_rsp_id: got %0d want 0", rsp_id); end
        total++; if (rsp_dst !== 3'd0) begin bad++; $display("FAIL reset_rsp_dst: got %0d want 0", rsp_dst); end
        req_valid = 4'h0;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #1;
            total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL idle_ready c%0d: got %b want 0000", c, req_ready); end
            total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL idle_rsp_valid c%0d: got %b want 0", c, rsp_valid); end
            @(negedge clk);
        end
    endtask

    task automatic test_single();
        do_reset();
        rsp_ready = 1'b1;
        req_src0  = 4'b0100;
        req_src1  = {3'b000, 3'b111, 3'b000, 3'b000};
        req_valid = 4'b0100;
        #1;
        total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL single_grant: got %b want 0100", req_ready); end
        @(negedge clk);
        req_valid = 4'b0000;
        #1;
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL single_one_cycle: got %b want 0000", req_ready); end
        total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL single_rsp_valid: got %b want 1", rsp_valid); end
        total++; if (rsp_id !== 2'd2) begin bad++; $display("FAIL single_rsp_id: got %0d want 2", rsp_id); end
        total++; if (rsp_dst !== 3'd7) begin bad++; $display("FAIL single_rsp_dst: got %0d want 7", rsp_dst); end
        @(negedge clk);
        #1;
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL single_drained: got %b want 0", rsp_valid); end
    endtask

    task automatic test_round_robin();
        int         order [5];
        logic [2:0] dexp  [4];
        order = '{0, 1, 2, 3, 0};
        dexp  = '{3'd1, 3'd4, 3'd3, 3'd6};
        do_reset();
        rsp_ready = 1'b1;
        req_src0  = 4'b0101;
        req_src1  = {3'b111, 3'b001, 3'b011, 3'b000};
        req_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            #1;
            total++; if (req_ready !== 4'(1 << order[k])) begin bad++; $display("FAIL rr_grant k%0d: got %b want %b", k, req_ready, 4'(1 << order[k])); end
            if (k > 0) begin
                total++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(order[k-1]) || rsp_dst !== dexp[order[k-1]]) begin
                    bad++; $display("FAIL rr_rsp k%0d: got v=%b id=%0d dst=%0d want v=1 id=%0d dst=%0d",
                                    k, rsp_valid, rsp_id, rsp_dst, order[k-1], dexp[order[k-1]]);
                end
            end
            @(negedge clk);
        end
        req_valid = 4'h0;
        #1;
        total++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_dst !== 3'd1) begin
            bad++; $display("FAIL rr_rsp_last: got v=%b id=%0d dst=%0d want v=1 id=0 dst=1", rsp_valid, rsp_id, rsp_dst);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        do_reset();
        rsp_ready = 1'b0;
        req_src0  = 4'b0101;
        req_src1  = {3'b111, 3'b001, 3'b011, 3'b000};
        req_valid = 4'hF;
        #1;
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL bp_grant0: got %b want 0001", req_ready); end
        @(negedge clk); #1;
        total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL bp_grant1: got %b want 0010", req_ready); end
        @(negedge clk); #1;
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL bp_full_c2: got %b want 0000", req_ready); end
        total++; if (rsp_id !== 2'd0 || rsp_dst !== 3'd1) begin bad++; $display("FAIL bp_head_c2: got id=%0d dst=%0d want id=0 dst=1", rsp_id, rsp_dst); end
        @(negedge clk); #1;
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL bp_full_c3: got %b want 0000", req_ready); end
        total++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_dst !== 3'd1) begin bad++; $display("FAIL bp_head_stable: got v=%b id=%0d dst=%0d want v=1 id=0 dst=1", rsp_valid, rsp_id, rsp_dst); end
        rsp_ready = 1'b1;
        #1;
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL bp_bubble: got %b want 0000", req_ready); end
        @(negedge clk); #1;
        total++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_dst !== 3'd4) begin bad++; $display("FAIL bp_drain1: got v=%b id=%0d dst=%0d want v=1 id=1 dst=4", rsp_valid, rsp_id, rsp_dst); end
        total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL bp_resume: got %b want 0100", req_ready); end
        @(negedge clk); #1;
        total++; if (rsp_id !== 2'd2 || rsp_dst !== 3'd3) begin bad++; $display("FAIL bp_after_resume: got id=%0d dst=%0d want id=2 dst=3", rsp_id, rsp_dst); end
        total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL bp_grant3: got %b want 1000", req_ready); end
        req_valid = 4'h0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_exhaustive();
        logic [3:0] v;
        logic [2:0] want;
        do_reset();
        rsp_ready = 1'b1;
        req_valid = 4'b0001;
        for (int n = 0; n <= 16; n++) begin
            if (n < 16) begin
                v        = 4'(n);
                req_src0 = {3'b000, v[0]};
                req_src1 = {9'd0, v[3:1]};
            end else begin
                req_valid = 4'b0000;
            end
            #1;
            if (n < 16) begin
                total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL ex_grant n%0d: got %b want 0001", n, req_ready); end
            end
            if (n > 0) begin
                v    = 4'(n - 1);
                want = 3'(v[0]) + 3'(2 * (v[1] + v[2] + v[3]));
                total++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_dst !== want) begin
                    bad++; $display("FAIL ex_dst v%0d: got v=%b id=%0d dst=%0d want v=1 id=0 dst=%0d", n - 1, rsp_valid, rsp_id, rsp_dst, want);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        rsp_ready = 1'b0;
        req_src0  = 4'b0101;
        req_src1  = {3'b111, 3'b001, 3'b011, 3'b000};
        req_valid = 4'hF;
        repeat (3) @(negedge clk);
        #1;
        total++; if (rsp_valid !== 1'b1 || req_ready !== 4'b0000) begin bad++; $display("FAIL mid_prefull: got v=%b ready=%b want v=1 ready=0000", rsp_valid, req_ready); end
        #1;
        rst = 1'b1;
        #1;
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL mid_async_valid: got %b want 0", rsp_valid); end
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL mid_async_ready: got %b want 0000", req_ready); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL mid_ptr0: got %b want 0001", req_ready); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL mid_empty: got %b want 0", rsp_valid); end
        req_valid = 4'h0;
        @(negedge clk); #1;
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL mid_no_stale: got %b want 0", rsp_valid); end
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        req_src0  = '0;
        req_src1  = '0;
        @(negedge clk);
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_exhaustive();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
